rob_commit: RTL
===============

Name: rob_commit

Overview:
- Retire stage at the head end of the reorder buffer.
- The issue side allocates entries at the ROB tail; this block consumes completed entries at the ROB head in program order.
- It writes results to the register file, releases stores to the load/store buffer, resolves branch predictions and redirects the front end on a mispredict or JALR.
- It pops the head with a single-cycle handshake.

Parameters:
BITS, 4, ROB index width; ROB depth is 2^BITS

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  pause when low
head_valid  input  1  ROB head entry occupied
head_ready  input  1  head entry result written back
head_id  input  BITS  ROB index of head
head_type  input  2  0=reg-write, 1=branch, 2=store, 3=jalr
head_rd  input  5  destination register
head_value  input  32  result; branch: {pc[31:1], predicted_taken}
head_dest  input  32  branch: fail-path pc; jalr: jump target
head_taken  input  1  branch: resolved direction
store_ack  input  1  LSB has performed the committed store
commit_pop  output  1  combinational; advance ROB head this cycle
rf_we  output  1  register-file write strobe
rf_rd  output  5  write register
rf_value  output  32  write data
rf_robid  output  BITS  ROB id being retired (clears RF dependency tag)
store_commit_req  output  1  permission for LSB to execute head store
bp_upd_valid  output  1  predictor update strobe
bp_upd_pc  output  32  branch pc ({head_value[31:1],1'b0})
bp_upd_taken  output  1  resolved direction
flush  output  1  squash all speculative state
redirect_valid  output  1  front-end pc redirect strobe
redirect_pc  output  32  new fetch pc
stall_release  output  1  clears issue stall raised by a jalr

Behaviour:
- Reset (rst_in low, async): state=IDLE; every output register = 0. Reset mid-store-wait drops store_commit_req immediately.
- States: IDLE, STORE_WAIT, FLUSH.
- All outputs except commit_pop are registered. Their effects appear exactly one cycle after the commit cycle. Strobes are single-cycle pulses.
- commit_pop is combinational:
  - IDLE: commit_pop = rdy_in & head_valid & head_ready & (head_type != store).
  - STORE_WAIT: commit_pop = rdy_in & store_ack.
  - FLUSH: commit_pop = 0.
- IDLE, reg-write committed: rf_we=1 next cycle with rf_rd=head_rd, rf_value=head_value, rf_robid=head_id. When head_rd==0, rf_we=0 but the pop still happens.
- IDLE, branch committed: bp_upd_valid=1, bp_upd_pc, bp_upd_taken=head_taken.
  - If head_taken != head_value[0]: flush=1, redirect_valid=1, redirect_pc=head_dest, and go to FLUSH.
  - Otherwise stay in IDLE.
- IDLE, jalr committed: rf write of head_value to head_rd (same rd==0 rule), redirect_valid=1, redirect_pc=head_dest, stall_release=1. No flush; stay in IDLE.
- IDLE, store at head and ready: commit_pop=0. store_commit_req=1 next cycle; go to STORE_WAIT.
- STORE_WAIT: store_commit_req held high.
  - Pop in the same cycle store_ack arrives; store_commit_req falls next cycle; return to IDLE.
  - store_ack outside STORE_WAIT is ignored.
- FLUSH: one dead cycle. The head is ignored because the ROB is being cleared; return to IDLE unconditionally.
- rdy_in low: state frozen, no pop, all strobes 0 next cycle. store_commit_req holds its value.
- head_valid low or head_ready low in IDLE: no action, no strobes.
- Throughput: one non-store commit per cycle. A store costs at least 2 cycles (request, ack).

Optional Feature:
- Macro COMMIT_PERF_COUNTERS_EN.
- When defined, add outputs perf_retired[31:0] and perf_mispredict[31:0]:
  - perf_retired increments on every commit_pop.
  - perf_mispredict increments on every flush.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reg-write entry (rd=5, value=0x1234, id=3), head ready -> commit_pop=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_value=0x1234, rf_robid=3.
- Reg-write entry with rd=0 -> commit_pop=1, rf_we stays 0.
- Store at head, store_ack asserted 3 cycles after request -> store_commit_req high for 4 cycles, commit_pop=1 only in the ack cycle, then IDLE.
- Branch with value=0x00001001 (predicted taken), head_taken=0, dest=0x1004 -> next cycle flush=1, redirect_pc=0x1004, bp_upd_pc=0x1000, bp_upd_taken=0; commit_pop=0 in the FLUSH cycle even with a ready head.
- jalr (rd=1, value=0x2008, dest=0x3000) -> rf write x1=0x2008, redirect_pc=0x3000, stall_release=1, flush=0.
- Reset pulled low during STORE_WAIT -> store_commit_req=0 immediately, state IDLE after release; rdy_in low with ready head -> no pop, no strobes.

Source files
------------

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit
// Purpose  : Retire stage at the reorder-buffer head. Consumes completed
//            entries in program order, writes register results, hands stores
//            to the load/store buffer, updates the branch predictor and
//            redirects the front end on a mispredict or a JALR.
// Ports    : clk_in / rst_in (async, active-low) / rdy_in (global pause)
//            head_*            - ROB head entry fields
//            store_ack         - LSB has performed the released store
//            commit_pop        - combinational head advance
//            rf_*              - register-file write port (registered)
//            store_commit_req  - store release to LSB (registered, level)
//            bp_upd_*          - predictor update (registered strobe)
//            flush, redirect_* - squash / front-end redirect (registered)
//            stall_release     - clears the issue stall raised by a JALR
// Options  : COMMIT_PERF_COUNTERS_EN adds perf_retired / perf_mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit #(
    parameter int BITS = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            head_valid,
    input  logic            head_ready,
    input  logic [BITS-1:0] head_id,
    input  logic [1:0]      head_type,
    input  logic [4:0]      head_rd,
    input  logic [31:0]     head_value,
    input  logic [31:0]     head_dest,
    input  logic            head_taken,
    input  logic            store_ack,
    output logic            commit_pop,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [31:0]     rf_value,
    output logic [BITS-1:0] rf_robid,
    output logic            store_commit_req,
    output logic            bp_upd_valid,
    output logic [31:0]     bp_upd_pc,
    output logic            bp_upd_taken,
    output logic            flush,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
`ifdef COMMIT_PERF_COUNTERS_EN
    output logic [31:0]     perf_retired,
    output logic [31:0]     perf_mispredict,
`endif
    output logic            stall_release
);

    localparam logic [1:0] c_TYPE_REG    = 2'd0;
    localparam logic [1:0] c_TYPE_BRANCH = 2'd1;
    localparam logic [1:0] c_TYPE_STORE  = 2'd2;
    localparam logic [1:0] c_TYPE_JALR   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_STORE_WAIT = 2'd1,
        S_FLUSH      = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_head_go;      // head entry can be acted on this cycle
    logic w_commit_idle;  // non-store commit from IDLE
    logic w_rf_write;
    logic w_bp_update;
    logic w_mispredict;
    logic w_jalr;

    always_comb begin
        w_head_go     = rdy_in & head_valid & head_ready;
        w_commit_idle = (r_state == S_IDLE) & w_head_go & (head_type != c_TYPE_STORE);
        // x0 is hardwired zero: the entry retires but nothing is written.
        w_rf_write    = w_commit_idle & ((head_type == c_TYPE_REG) | (head_type == c_TYPE_JALR))
                        & (head_rd != 5'd0);
        w_bp_update   = w_commit_idle & (head_type == c_TYPE_BRANCH);
        // head_value[0] carries the predicted direction for branches.
        w_mispredict  = w_bp_update & (head_taken != head_value[0]);
        w_jalr        = w_commit_idle & (head_type == c_TYPE_JALR);
    end

    always_comb begin
        commit_pop   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_head_go) begin
                    if (head_type == c_TYPE_STORE) begin
                        w_next_state = S_STORE_WAIT;
                    end else begin
                        commit_pop = 1'b1;
                        if (w_mispredict) begin
                            w_next_state = S_FLUSH;
                        end
                    end
                end
            end
            S_STORE_WAIT: begin
                if (rdy_in && store_ack) begin
                    commit_pop   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_FLUSH: begin
                // Dead cycle while the ROB clears; a pause still freezes it.
                if (rdy_in) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state          <= S_IDLE;
            rf_we            <= 1'b0;
            rf_rd            <= 5'd0;
            rf_value         <= 32'd0;
            rf_robid         <= '0;
            store_commit_req <= 1'b0;
            bp_upd_valid     <= 1'b0;
            bp_upd_pc        <= 32'd0;
            bp_upd_taken     <= 1'b0;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= 32'd0;
            stall_release    <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            rf_we            <= w_rf_write;
            bp_upd_valid     <= w_bp_update;
            flush            <= w_mispredict;
            redirect_valid   <= w_mispredict | w_jalr;
            stall_release    <= w_jalr;
            // High for exactly the cycles spent waiting on the LSB; a pause
            // keeps the state, so the request level is held as well.
            store_commit_req <= (w_next_state == S_STORE_WAIT);
            if (w_rf_write) begin
                rf_rd    <= head_rd;
                rf_value <= head_value;
                rf_robid <= head_id;
            end
            if (w_bp_update) begin
                bp_upd_pc    <= {head_value[31:1], 1'b0};
                bp_upd_taken <= head_taken;
            end
            if (w_mispredict || w_jalr) begin
                redirect_pc <= head_dest;
            end
        end
    end

`ifdef COMMIT_PERF_COUNTERS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_retired    <= 32'd0;
            perf_mispredict <= 32'd0;
        end else begin
            if (commit_pop) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (w_mispredict) begin
                perf_mispredict <= perf_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
